// File: rtl/noc_pkg.sv
// noc_pkg: helpers shared by the NoC flit serializer and deserializer.
//   flit_width() - payload bits carried by one flit for a given beat width
//                  and serialization factor.
// flit_t is declared locally by each user because its field widths follow
// that module's own parameters.
package noc_pkg;

    function automatic int unsigned flit_width(input int unsigned tdata_width,
                                               input int unsigned factor);
        return tdata_width / factor;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous FIFO of flits {data, dest, is_tail}.
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en              push a flit (ignored while full)
//   wr_data/dest/tail  flit being pushed
//   rd_en              pop the head flit (ignored while empty)
//   full, empty        occupancy flags
//   head_data/dest/tail head flit, read combinationally
module flit_fifo #(
    parameter int unsigned FLIT_WIDTH  = 128,
    parameter int unsigned TDEST_WIDTH = 6,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [FLIT_WIDTH-1:0]  wr_data,
    input  logic [TDEST_WIDTH-1:0] wr_dest,
    input  logic                   wr_tail,
    input  logic                   rd_en,
    output logic                   full,
    output logic                   empty,
    output logic [FLIT_WIDTH-1:0]  head_data,
    output logic [TDEST_WIDTH-1:0] head_dest,
    output logic                   head_tail
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0]  data;
        logic [TDEST_WIDTH-1:0] dest;
        logic                   is_tail;
    } flit_t;

    flit_t        mem [DEPTH];
    logic [AW:0]  wr_ptr;    // MSB is the wrap bit
    logic [AW:0]  rd_ptr;
    logic         push;
    logic         pop;

    // Index wraps at DEPTH-1 so non-power-of-two depths also work.
    function automatic logic [AW:0] ptr_next(input logic [AW:0] p);
        if (p[AW-1:0] == AW'(DEPTH - 1))
            return {~p[AW], {AW{1'b0}}};
        return p + (AW + 1)'(1);
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{data: wr_data, dest: wr_dest, is_tail: wr_tail};
    end

    assign head_data = mem[rd_ptr[AW-1:0]].data;
    assign head_dest = mem[rd_ptr[AW-1:0]].dest;
    assign head_tail = mem[rd_ptr[AW-1:0]].is_tail;

endmodule

// File: rtl/axis_flit_deserializer.sv
// axis_flit_deserializer: NoC receive endpoint. Buffers credit-flow-controlled
// flits, returns one credit per popped flit and packs SERIALIZATION_FACTOR
// flits (fewer on a tail) into one AXI-Stream beat, flit 0 in the LSBs.
//   clk, rst_n                  clock, asynchronous active-low reset
//   data_in/dest_in/is_tail_in  incoming flit, qualified by send_in
//   credit_out                  one-cycle pulse per popped flit
//   axis_t*                     AXI-Stream master (valid/ready/data/last/dest)
//   overflow_err                sticky: a flit arrived while the FIFO was full
module axis_flit_deserializer
    import noc_pkg::*;
#(
    parameter  int unsigned TDEST_WIDTH          = 6,
    parameter  int unsigned TDATA_WIDTH          = 512,
    parameter  int unsigned SERIALIZATION_FACTOR = 4,
    parameter  int unsigned FLIT_BUFFER_DEPTH    = 4,
    localparam int unsigned FLIT_WIDTH           = flit_width(TDATA_WIDTH, SERIALIZATION_FACTOR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [TDEST_WIDTH-1:0] dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_tvalid,
    input  logic                   axis_tready,
    output logic [TDATA_WIDTH-1:0] axis_tdata,
    output logic                   axis_tlast,
    output logic [TDEST_WIDTH-1:0] axis_tdest,
    output logic                   overflow_err
);
    localparam int unsigned CW = $clog2(SERIALIZATION_FACTOR);

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FLIT_WIDTH-1:0]  head_data;
    logic [TDEST_WIDTH-1:0] head_dest;
    logic                   head_tail;

    logic [CW-1:0]          cnt;
    logic [TDATA_WIDTH-1:0] asm_data;
    logic [TDEST_WIDTH-1:0] asm_dest;
    logic [TDATA_WIDTH-1:0] merged;
    logic [TDEST_WIDTH-1:0] beat_dest;
    logic                   completing;
    logic                   pop;

    flit_fifo #(
        .FLIT_WIDTH (FLIT_WIDTH),
        .TDEST_WIDTH(TDEST_WIDTH),
        .DEPTH      (FLIT_BUFFER_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (send_in),
        .wr_data  (data_in),
        .wr_dest  (dest_in),
        .wr_tail  (is_tail_in),
        .rd_en    (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_data(head_data),
        .head_dest(head_dest),
        .head_tail(head_tail)
    );

    assign completing = (cnt == CW'(SERIALIZATION_FACTOR - 1)) || head_tail;
    // Only a completing flit needs room in the output register.
    assign pop        = !fifo_empty && (!completing || !axis_tvalid || axis_tready);
    assign beat_dest  = (cnt == '0) ? head_dest : asm_dest;

    // Slots above cnt stay zero because the assembly register is cleared
    // whenever a beat completes.
    always_comb begin
        merged = asm_data;
        for (int unsigned i = 0; i < SERIALIZATION_FACTOR; i++) begin
            if (CW'(i) == cnt) merged[i*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_err <= 1'b0;
        end else if (send_in && fifo_full) begin
            overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            asm_data    <= '0;
            asm_dest    <= '0;
            axis_tvalid <= 1'b0;
            axis_tdata  <= '0;
            axis_tlast  <= 1'b0;
            axis_tdest  <= '0;
            credit_out  <= 1'b0;
        end else begin
            credit_out <= pop;
            if (axis_tvalid && axis_tready) axis_tvalid <= 1'b0;
            if (pop) begin
                if (completing) begin
                    // A reload here overrides the handshake clear above.
                    axis_tvalid <= 1'b1;
                    axis_tdata  <= merged;
                    axis_tlast  <= head_tail;
                    axis_tdest  <= beat_dest;
                    cnt         <= '0;
                    asm_data    <= '0;
                end else begin
                    asm_data <= merged;
                    asm_dest <= beat_dest;
                    cnt      <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_flit_deserializer.sv
// tb_axis_flit_deserializer: randomized bench for axis_flit_deserializer.
// A credit-respecting sender feeds flits; a packet-level model chops each
// packet into groups of S flits to predict the beats, and a negedge monitor
// compares every handshaken beat against that prediction.
module tb_axis_flit_deserializer;
    localparam int unsigned DW    = 6;
    localparam int unsigned TW    = 512;
    localparam int unsigned S     = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FW    = TW / S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] data_in = '0;
    logic [DW-1:0] dest_in = '0;
    logic          is_tail_in = 1'b0;
    logic          send_in = 1'b0;
    logic          credit_out;
    logic          axis_tvalid;
    logic          axis_tready = 1'b0;
    logic [TW-1:0] axis_tdata;
    logic          axis_tlast;
    logic [DW-1:0] axis_tdest;
    logic          overflow_err;

    always #5 clk = ~clk;

    axis_flit_deserializer #(
        .TDEST_WIDTH         (DW),
        .TDATA_WIDTH         (TW),
        .SERIALIZATION_FACTOR(S),
        .FLIT_BUFFER_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .dest_in     (dest_in),
        .is_tail_in  (is_tail_in),
        .send_in     (send_in),
        .credit_out  (credit_out),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .axis_tdata  (axis_tdata),
        .axis_tlast  (axis_tlast),
        .axis_tdest  (axis_tdest),
        .overflow_err(overflow_err)
    );

    typedef struct { logic [FW-1:0] data; logic [DW-1:0] dest; logic tail; } flit_rec_t;
    typedef struct { logic [TW-1:0] data; logic [DW-1:0] dest; logic last; } beat_rec_t;

    flit_rec_t cur_q[$];
    beat_rec_t exp_q[$];

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   credits = DEPTH;
    int   cred_total = 0;
    int   flits_sent = 0;
    int   cyc = 0;
    logic trace_on = 1'b0;
    int   trace_base = 0;
    logic [7:0] cr_trace = '0;
    logic [7:0] tv_trace = '0;
    logic rand_ready = 1'b0;
    logic bp_done = 1'b0;

    task automatic check_val(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packet-level reference: a beat closes after S flits or at a tail.
    function automatic void model_accept(input logic [FW-1:0] d, input logic [DW-1:0] ds, input logic tl);
        beat_rec_t b;
        cur_q.push_back('{d, ds, tl});
        if (cur_q.size() == S || tl) begin
            b.data = '0;
            foreach (cur_q[i]) b.data |= TW'(cur_q[i].data) << (i * FW);
            b.dest = cur_q[0].dest;
            b.last = tl;
            exp_q.push_back(b);
            cur_q.delete();
        end
    endfunction

    function automatic logic [FW-1:0] rand_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered and left at posedge+1; waits for a credit, then drives one cycle.
    task automatic send_flit(input logic [FW-1:0] d, input logic [DW-1:0] ds, input logic tl);
        int unsigned waited = 0;
        while (credits == 0 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        if (credits == 0) begin
            check_val("credit_wait", TW'(credits), TW'(1));
            return;
        end
        send_in = 1'b1; data_in = d; dest_in = ds; is_tail_in = tl;
        credits--;
        flits_sent++;
        model_accept(d, ds, tl);
        @(posedge clk); #1;
        send_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, TW'(exp_q.size()), TW'(0));
        repeat (3) begin @(posedge clk); #1; end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    always @(negedge clk) begin
        beat_rec_t b;
        if (rst_n) begin
            if (credit_out) begin
                credits++;
                cred_total++;
            end
            if (axis_tvalid && axis_tready) begin
                if (exp_q.size() == 0) begin
                    check_val("beat_expected", TW'(axis_tvalid), TW'(0));
                end else begin
                    b = exp_q.pop_front();
                    check_val("tdata", axis_tdata, b.data);
                    check_val("tdest", TW'(axis_tdest), TW'(b.dest));
                    check_val("tlast", TW'(axis_tlast), TW'(b.last));
                end
            end
        end
        if (trace_on && (cyc - trace_base) >= 0 && (cyc - trace_base) < 8) begin
            cr_trace[cyc - trace_base] = credit_out;
            tv_trace[cyc - trace_base] = axis_tvalid;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] exp_beat;
        int cred_base;
        int sent_base;
        int unsigned n;
        int unsigned len;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_tvalid", TW'(axis_tvalid), TW'(0));
        check_val("rst_tdata", axis_tdata, '0);
        check_val("rst_tlast", TW'(axis_tlast), TW'(0));
        check_val("rst_tdest", TW'(axis_tdest), TW'(0));
        check_val("rst_credit", TW'(credit_out), TW'(0));
        check_val("rst_ovf", TW'(overflow_err), TW'(0));

        // Full beat with latency trace, output held while tready=0
        @(posedge clk); #1;
        axis_tready = 1'b0;
        cr_trace = '0; tv_trace = '0; trace_base = cyc; trace_on = 1'b1;
        send_flit(FW'(1), 6'h15, 1'b0);
        send_flit(FW'(2), 6'h15, 1'b0);
        send_flit(FW'(3), 6'h15, 1'b0);
        send_flit(FW'(4), 6'h15, 1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        trace_on = 1'b0;
        check_val("credit_trace", TW'(cr_trace), TW'(8'h3C));
        check_val("tvalid_trace", TW'(tv_trace), TW'(8'hE0));
        exp_beat = '0;
        exp_beat[0*FW +: FW] = FW'(1);
        exp_beat[1*FW +: FW] = FW'(2);
        exp_beat[2*FW +: FW] = FW'(3);
        exp_beat[3*FW +: FW] = FW'(4);
        check_val("full_tdata", axis_tdata, exp_beat);
        check_val("full_tlast", TW'(axis_tlast), TW'(1));
        check_val("full_tdest", TW'(axis_tdest), TW'(6'h15));
        axis_tready = 1'b1;
        wait_drain("drain_full");

        // Short tail: upper slots zero, dest from the first flit
        axis_tready = 1'b0;
        send_flit(FW'('hA), 6'h2A, 1'b0);
        send_flit(FW'('hB), 6'h0B, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        exp_beat = '0;
        exp_beat[0*FW +: FW] = FW'('hA);
        exp_beat[1*FW +: FW] = FW'('hB);
        check_val("short_tvalid", TW'(axis_tvalid), TW'(1));
        check_val("short_tdata", axis_tdata, exp_beat);
        check_val("short_tlast", TW'(axis_tlast), TW'(1));
        check_val("short_tdest", TW'(axis_tdest), TW'(6'h2A));
        axis_tready = 1'b1;
        wait_drain("drain_short");

        // Backpressure: 12 flits, credit-paced, output stalled
        axis_tready = 1'b0;
        cred_base = cred_total;
        sent_base = flits_sent;
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    send_flit(rand_flit(), DW'(i / 4 + 1), (i % 4) == 3);
                bp_done = 1'b1;
            end
        join_none
        repeat (40) begin @(posedge clk); #1; end
        check_val("bp_credits", TW'(cred_total - cred_base), TW'(7));
        check_val("bp_sent", TW'(flits_sent - sent_base), TW'(11));
        check_val("bp_tvalid", TW'(axis_tvalid), TW'(1));
        check_val("bp_held_tdata", axis_tdata, exp_q[0].data);
        check_val("bp_held_tdest", TW'(axis_tdest), TW'(exp_q[0].dest));
        axis_tready = 1'b1;
        n = 0;
        while (!bp_done && n < 500) begin @(posedge clk); #1; n++; end
        check_val("bp_done", TW'(bp_done), TW'(1));
        wait_drain("drain_bp");

        // Overflow: fifo fills behind a blocked completing head
        axis_tready = 1'b0;
        send_flit(rand_flit(), 6'h01, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) send_flit(rand_flit(), DW'(i + 2), 1'b1);
        check_val("ovf_before", TW'(overflow_err), TW'(0));
        send_in = 1'b1; data_in = rand_flit(); dest_in = 6'h3E; is_tail_in = 1'b1;
        @(posedge clk); #1;
        send_in = 1'b0;
        check_val("ovf_set", TW'(overflow_err), TW'(1));
        repeat (5) begin @(posedge clk); #1; end
        check_val("ovf_sticky", TW'(overflow_err), TW'(1));
        check_val("ovf_no_credit", TW'(credits), TW'(0));
        axis_tready = 1'b1;
        wait_drain("drain_ovf");
        check_val("ovf_no_extra", TW'(axis_tvalid), TW'(0));

        // Reset mid-packet with a pending output beat
        axis_tready = 1'b0;
        send_flit(rand_flit(), 6'h3F, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        send_flit(rand_flit(), 6'h11, 1'b0);
        send_flit(rand_flit(), 6'h11, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        cur_q.delete();
        #1;
        check_val("mrst_tvalid", TW'(axis_tvalid), TW'(0));
        check_val("mrst_tdata", axis_tdata, '0);
        check_val("mrst_tlast", TW'(axis_tlast), TW'(0));
        check_val("mrst_tdest", TW'(axis_tdest), TW'(0));
        check_val("mrst_ovf", TW'(overflow_err), TW'(0));
        repeat (2) @(posedge clk);
        #1;
        credits = DEPTH;
        rst_n = 1'b1;
        axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_flit(rand_flit(), 6'h22, i == 3);
        wait_drain("drain_mrst");

        // Random stress
        cred_base = cred_total;
        sent_base = flits_sent;
        rand_ready = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 12);
            for (int unsigned f = 0; f < len; f++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                end
                send_flit(rand_flit(), DW'($urandom), f == len - 1);
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #3;
        axis_tready = 1'b1;
        wait_drain("drain_stress");
        repeat (4) begin @(posedge clk); #1; end
        check_val("stress_partial", TW'(cur_q.size()), TW'(0));
        check_val("stress_ovf", TW'(overflow_err), TW'(0));
        check_val("stress_credits", TW'(cred_total - cred_base), TW'(flits_sent - sent_base));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/axis_flit_deserializer.md
# axis_flit_deserializer

Single-clock receive endpoint for a NoC router output port. Accepts credit-flow-controlled flits (data, dest, tail, send), buffers them, and returns one credit per consumed flit. Reassembles every SERIALIZATION_FACTOR flits into one AXI-Stream beat. It is the receiving counterpart of the flit serializer that injects packets into the ring, for designs where user logic runs on the NoC clock.

## Interface
- TDEST_WIDTH, 6: width of the dest field carried on every flit and presented on axis_tdest.
- TDATA_WIDTH, 512: AXIS beat width. Must be divisible by SERIALIZATION_FACTOR.
- SERIALIZATION_FACTOR, 4: flits per full beat (S). Must be ≥ 2.
- FLIT_BUFFER_DEPTH, 4: input FIFO depth. Equals the credit count the upstream sender holds after reset. Must be ≥ 2.
- FLIT_WIDTH (localparam) = TDATA_WIDTH / SERIALIZATION_FACTOR.
---
- clk  in  1  NoC clock. All logic is on this clock.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  FLIT_WIDTH  flit payload.
- dest_in  in  TDEST_WIDTH  flit destination.
- is_tail_in  in  1  the flit is the last flit of its packet.
- send_in  in  1  flit valid. Upstream may assert it only while it holds a credit.
- credit_out  out  1  one-cycle pulse returning one credit per flit popped.
- axis_tvalid  out  1  output beat valid.
- axis_tready  in  1  downstream ready.
- axis_tdata  out  TDATA_WIDTH  reassembled beat.
- axis_tlast  out  1  the beat contains a tail flit.
- axis_tdest  out  TDEST_WIDTH  dest of the beat's first flit.
- overflow_err  out  1  sticky flag: a flit arrived while the FIFO was full.

## Operation
- **Flit FIFO**
  - Write on send_in when not full. Head is read combinationally.
  - send_in while full: drop the flit and set overflow_err. overflow_err clears only on reset.
- **Assembly**
  - Slot counter cnt counts 0..S-1.
  - The popped flit goes to slice [cnt*FLIT_WIDTH +: FLIT_WIDTH]. Flit 0 is the LSBs.
  - dest is captured when cnt==0.
- **Completing flit**: cnt==S-1 or is_tail=1.
  - On pop, the output register loads the assembled data with the flit merged in, and axis_tlast = is_tail.
  - Slots above cnt are zero-filled (short tail beat).
  - cnt returns to 0 and the assembly register is cleared.
- **Pop rule**: pop = !empty && (!completing || !axis_tvalid || axis_tready).
  - Non-completing flits always pop.
- credit_out is a registered copy of pop.
- **Output register**
  - Holds tdata/tlast/tdest stable while tvalid && !tready.
  - Clears tvalid on handshake unless reloaded in the same cycle.
- Back-to-back packets need no gap. A flit following a tail starts a new beat at slot 0.

## Timing
- **Reset values**: axis_tvalid=0, axis_tdata=0, axis_tlast=0, axis_tdest=0, credit_out=0, overflow_err=0, FIFO empty, cnt=0.
- **Latency**
  - Flit sent at cycle t is poppable at t+1. Its credit_out pulse is at t+2.
  - Completing flit popped at cycle c gives axis_tvalid=1 at c+1.
  - S flits sent back-to-back at t..t+S-1 give axis_tvalid high at t+S+1.
- **Throughput**: one flit per cycle sustained with tready=1, i.e. one beat every S cycles, no bubbles.
- **Simultaneous events**
  - Handshake and reload in the same cycle: the new beat appears at the next edge and tvalid stays 1.
  - send_in with pop while full (count==DEPTH): treated as full, so the flit is dropped and flagged. A compliant sender cannot do this.
- **Reset mid-packet**
  - Partial beat, FIFO contents and the pending output are discarded.
  - No credits are returned; the upstream sender is reset to FLIT_BUFFER_DEPTH credits by the same rst_n.

## Structure
- Shared package noc_pkg: FLIT_WIDTH computation helper and a flit_t struct {data, dest, is_tail}, parameterized via localparams at the use site.
- Sub-module flit_fifo: flit_t entries, depth FLIT_BUFFER_DEPTH, $clog2-sized pointers with wrap bit, async active-low reset, outputs full/empty/head. Reusable by the serializer side.
- Top holds the assembly counter, assembly register and output register. Target ~200 lines total.

## Test plan
- **Full beat**: S=4, FLIT_WIDTH=128; flits 0x1,0x2,0x3,0x4 (tail on 4th), dest=0x15 at t..t+3.
  - tvalid at t+5, tdata={0x4,0x3,0x2,0x1}, tlast=1, tdest=0x15.
  - Four credit pulses at t+2..t+5.
- **Short tail**: 2 flits 0xA,0xB with tail on the 2nd.
  - tdata = {0,0,0xB,0xA}, tlast=1, cnt returns to 0.
- **Backpressure**: tready=0, 12 flits streamed on 4 credits, fed only as credits return.
  - First beat is held stable.
  - Exactly 4+3 credits returned before stall: 3 pops into assembly, 4 left in the FIFO.
  - Release tready: remaining beats arrive in order, no loss.
- **Overflow**: 5 sends with no credit returned while the output is stalled.
  - overflow_err=1 and stays 1.
  - The 5th flit is absent from the output.
- **Reset mid-packet**: rst_n low after 2 of 4 flits.
  - All outputs go to 0 immediately.
  - After release, a fresh 4-flit packet yields a correct beat with no residue.
- **Random stress**: 1000 packets, random lengths 1..12 flits, random tready.
  - Scoreboard matches exactly, overflow_err stays 0, credits returned equal flits sent.
